instr_fetch: RTL

- Fetch stage directly upstream of the synchronous instruction memory.
- Owns the PC and drives the memory address and active-low read strobe.
- Tracks the one-cycle memory latency and registers each returned word with its PC into the IF/ID output register for decode.
- Handles stalls with a one-entry skid buffer, self-redirects on J/JAL, and accepts external redirects from later stages.

---
 rtl/instr_fetch_pkg.sv | 35 +++
 rtl/instr_fetch_if.sv | 26 ++
 rtl/fetch_skid.sv | 42 ++++
 rtl/instr_fetch.sv | 97 +++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Opcode decoding for the J/JAL self-redirect lives here so decode can reuse it.
package instr_fetch_pkg;

    localparam logic [31:0] PC_RESET_DEF = 32'h0040_0000;
    localparam logic [31:0] PC_STEP_DEF  = 32'd4;

    localparam logic [5:0]  OPC_J   = 6'b000010;
    localparam logic [5:0]  OPC_JAL = 6'b000011;
    localparam logic [31:0] NOP     = 32'h0000_0000;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int TGT_HI = 25;
    localparam int TGT_LO = 0;

    // Jump region comes from the address of the word after the jump.
    localparam logic [31:0] JUMP_REGION_OFS = 32'd4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_word_t;

    function automatic logic is_jump(input logic [31:0] instr);
        return (instr[OPC_HI:OPC_LO] == OPC_J) || (instr[OPC_HI:OPC_LO] == OPC_JAL);
    endfunction

    function automatic logic [31:0] jump_target(input fetch_word_t w);
        logic [31:0] region;
        region = w.pc + JUMP_REGION_OFS;
        return {region[31:28], w.instr[TGT_HI:TGT_LO], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: control inputs, instruction memory port and IF/ID outputs.
// master = fetch stage, slave = surrounding pipeline / memory.
interface instr_fetch_if;
    import instr_fetch_pkg::*;

    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] Dato_Instru;
    logic [31:0] Dir_Instru;
    logic        ReadMem;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        instr_valid;

    modport master (
        input  stall, redirect_valid, redirect_pc, Dato_Instru,
        output Dir_Instru, ReadMem, instr_out, pc_out, instr_valid
    );

    modport slave (
        output stall, redirect_valid, redirect_pc, Dato_Instru,
        input  Dir_Instru, ReadMem, instr_out, pc_out, instr_valid
    );

endinterface

// File: rtl/fetch_skid.sv
// One-entry holding register catching the in-flight memory word while decode stalls.
module fetch_skid
    import instr_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        load,
    input  logic        drain,
    input  fetch_word_t d,
    output logic        vld,
    output fetch_word_t q
);

    logic        skid_v_q, skid_v_d;
    fetch_word_t word_q, word_d;

    always_comb begin
        skid_v_d = skid_v_q;
        word_d   = word_q;
        if (drain) skid_v_d = 1'b0;
        if (load) begin
            skid_v_d = 1'b1;
            word_d   = d;
        end
        if (flush) skid_v_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) skid_v_q <= 1'b0;
        else        skid_v_q <= skid_v_d;
    end

    // Payload is qualified by skid_v_q, so it needs no reset.
    always_ff @(posedge clk) begin
        word_q <= word_d;
    end

    assign vld = skid_v_q;
    assign q   = word_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues reads to the synchronous instruction memory,
// and registers returned words into IF/ID with stall, jump and redirect handling.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEF,
    parameter logic [31:0] PC_STEP  = PC_STEP_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        pend_v_q, pend_v_d;
    logic        instr_valid_q, instr_valid_d;
    fetch_word_t ifid_q, ifid_d;

    fetch_word_t src, skid_word;
    logic        skid_v, issue, src_v, accept, take_jump, skid_load, skid_drain;

    fetch_skid u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (bus.redirect_valid),
        .load  (skid_load),
        .drain (skid_drain),
        .d     (src),
        .vld   (skid_v),
        .q     (skid_word)
    );

    always_comb begin
        issue      = rst_n & ~bus.stall;
        src_v      = skid_v | pend_v_q;
        src        = skid_v ? skid_word : '{instr: bus.Dato_Instru, pc: pend_pc_q};
        accept     = src_v & ~bus.stall;
        take_jump  = accept & is_jump(src.instr);
        skid_load  = bus.stall & pend_v_q & ~skid_v;
        skid_drain = ~bus.stall;

        pc_d          = pc_q;
        pend_pc_d     = pend_pc_q;
        pend_v_d      = 1'b0;
        ifid_d        = ifid_q;
        instr_valid_d = instr_valid_q;

        if (issue) begin
            pend_v_d  = 1'b1;
            pend_pc_d = pc_q;
            pc_d      = pc_q + PC_STEP;
        end

        if (!bus.stall) begin
            instr_valid_d = src_v;
            if (src_v) ifid_d = src;
        end

        // No delay slot: the word issued alongside an accepted jump is discarded.
        if (take_jump) begin
            pc_d     = jump_target(src);
            pend_v_d = 1'b0;
        end

        if (bus.redirect_valid) begin
            pc_d          = bus.redirect_pc;
            pend_v_d      = 1'b0;
            instr_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q          <= PC_RESET;
            pend_v_q      <= 1'b0;
            instr_valid_q <= 1'b0;
            ifid_q        <= '{instr: NOP, pc: 32'h0};
        end else begin
            pc_q          <= pc_d;
            pend_v_q      <= pend_v_d;
            instr_valid_q <= instr_valid_d;
            ifid_q        <= ifid_d;
        end
    end

    always_ff @(posedge clk) begin
        pend_pc_q <= pend_pc_d;
    end

    assign bus.ReadMem     = ~issue;
    assign bus.Dir_Instru  = pc_q;
    assign bus.instr_out   = ifid_q.instr;
    assign bus.pc_out      = ifid_q.pc;
    assign bus.instr_valid = instr_valid_q;

endmodule
